ahb3lite_sram_slave: RTL and testbench

//  Parametrised AHB3-Lite single-port SRAM slave; next generation of the flat test memory.

---
 rtl/ahb3lite_sram_slave.sv | 199 +++++++++++++++++++
 tb/tb_ahb3lite_sram_slave.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_sram_slave.sv
// ahb3lite_sram_slave
//   AHB3-Lite single-port SRAM slave. It supports the pipelined address and data phases,
//   byte-lane writes selected by HSIZE and HADDR[1:0], a fixed number of wait states per
//   OKAY transfer, a two-cycle ERROR response for illegal accesses, write-to-read
//   forwarding, and a side-effect-free backdoor monitor read port.
//
// Ports
//   HCLK, HRESETn        bus clock; asynchronous active-low reset
//   HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY
//                        address-phase inputs (HBURST/HPROT/HMASTLOCK are ignored)
//   HWDATA               write data (data phase)
//   HREADYOUT, HRESP     slave ready / response
//   HRDATA               read data (data phase)
//   monitor_addr         word index for the backdoor read
//   monitor_data         combinational Memory[monitor_addr]
//   dbg_state            current FSM state, for observation only
//
// Handshake: a beat is accepted on a rising HCLK edge when HSEL & HREADY & HTRANS[1]
// are all high and this slave shows HREADYOUT=1. Its data phase then lasts until the
// first rising edge at which HREADYOUT=1 again. A write's HWDATA is committed on that edge.
module ahb3lite_sram_slave #(
    parameter int MEM_DEPTH   = 4096,
    parameter int HADDR_SIZE  = 32,
    parameter int WAIT_STATES = 0,
    localparam int MEM_AW     = $clog2(MEM_DEPTH)
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    input  logic [MEM_AW-1:0]     monitor_addr,
    output logic [31:0]           monitor_data,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    localparam logic [HADDR_SIZE-1:0] ADDR_LIMIT = HADDR_SIZE'(4 * MEM_DEPTH);
    localparam logic [3:0]            WS         = 4'(WAIT_STATES);

    logic [31:0] mem [MEM_DEPTH];

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Pending write: captured in the address phase, committed when its data phase ends.
    logic              wr_pend_q;
    logic [MEM_AW-1:0] wr_word_q;
    logic [3:0]        wr_be_q;

    logic              accept, legal, acc_ok, acc_err;
    logic              addr_oor, size_bad, misalign;
    logic [MEM_AW-1:0] acc_word;
    logic              commit;
    logic [31:0]       wr_mask;
    logic [31:0]       merged;

    logic unused_ok;
    assign unused_ok = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

    function automatic logic [3:0] lane_en(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            3'd0:    be = 4'b0001 << a;
            3'd1:    be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // ---------------- address-phase decode ----------------
    assign accept   = HSEL & HREADY & HTRANS[1] & HREADYOUT;
    assign addr_oor = (HADDR >= ADDR_LIMIT);
    assign size_bad = (HSIZE > 3'd2);
    assign misalign = ((HSIZE == 3'd1) & HADDR[0]) | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
    assign legal    = ~(addr_oor | size_bad | misalign);
    assign acc_ok   = accept & legal;
    assign acc_err  = accept & ~legal;
    assign acc_word = HADDR[MEM_AW+1:2];

    // A pending write only exists for OKAY beats, so IDLE means its data phase is ending.
    assign commit = wr_pend_q & (state_q == ST_IDLE);

    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < 4; i++) begin
            wr_mask[8*i +: 8] = {8{wr_be_q[i]}};
        end
    end

    // Word as it will look after this edge's commit; used to forward to a same-edge read.
    assign merged = (mem[wr_word_q] & ~wr_mask) | (HWDATA & wr_mask);

    // ---------------- FSM ----------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (acc_err) begin
                    state_d = ST_ERR1;
                end else if (acc_ok && (WS != 4'd0)) begin
                    state_d = ST_WAIT;
                    cnt_d   = WS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            ST_WAIT: HREADYOUT = 1'b0;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: HRESP = 1'b1;
            default: ;
        endcase
    end

    assign dbg_state = state_q;

    // ---------------- pending write and read data ----------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_pend_q <= 1'b0;
            wr_word_q <= '0;
            wr_be_q   <= 4'b0000;
            HRDATA    <= 32'h0;
        end else begin
            if (acc_ok && HWRITE) begin
                wr_pend_q <= 1'b1;
                wr_word_q <= acc_word;
                wr_be_q   <= lane_en(HSIZE, HADDR[1:0]);
            end else if (commit) begin
                wr_pend_q <= 1'b0;
            end

            if (acc_ok && !HWRITE) begin
                HRDATA <= (commit && (wr_word_q == acc_word)) ? merged : mem[acc_word];
            end
        end
    end

    // Memory array has no reset: contents survive HRESETn.
    always_ff @(posedge HCLK) begin
        if (commit && HRESETn) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be_q[i]) begin
                    mem[wr_word_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign monitor_data = mem[monitor_addr];

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// tb_ahb3lite_sram_slave
//   Directed bench for ahb3lite_sram_slave. Two instances share the address/data bus:
//   dut0 with no wait states and dut3 with three wait states, each selected by its own HSEL.
//   Each instance's HREADY is looped back from its own HREADYOUT.
module tb_ahb3lite_sram_slave;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    // ---------------- clock / reset ----------------
    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;
    logic HRESETn;

    // ---------------- shared bus ----------------
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hsel0, hsel3;

    logic        rdy0, rdy3, resp0, resp3;
    logic [31:0] rdata0, rdata3, mon0, mon3;
    logic [AW-1:0] mon_addr0, mon_addr3;
    logic [1:0]  st0, st3;

    ahb3lite_sram_slave #(.MEM_DEPTH(DEPTH), .HADDR_SIZE(32), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'd0), .HTRANS(htrans), .HMASTLOCK(1'b0),
        .HREADY(rdy0), .HWDATA(hwdata), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0),
        .monitor_addr(mon_addr0), .monitor_data(mon0), .dbg_state(st0)
    );

    ahb3lite_sram_slave #(.MEM_DEPTH(DEPTH), .HADDR_SIZE(32), .WAIT_STATES(3)) dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(3'd1), .HPROT(4'd3), .HTRANS(htrans), .HMASTLOCK(1'b0),
        .HREADY(rdy3), .HWDATA(hwdata), .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rdata3),
        .monitor_addr(mon_addr3), .monitor_data(mon3), .dbg_state(st3)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic cur_rdy(input bit d3);
        return d3 ? rdy3 : rdy0;
    endfunction

    function automatic logic cur_resp(input bit d3);
        return d3 ? resp3 : resp0;
    endfunction

    function automatic logic [31:0] cur_rdata(input bit d3);
        return d3 ? rdata3 : rdata0;
    endfunction

    // ---------------- driver tasks ----------------
    // Single non-pipelined transfer; starts and ends 1 time unit after a rising edge.
    task automatic xfer(input bit d3, input bit wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic resp_or,
                        output logic resp_and, output int lows);
        hsel0  = !d3;
        hsel3  = d3;
        htrans = 2'd2;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        @(posedge HCLK); #1;
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        htrans = 2'd0;
        hwdata = wdata;
        lows     = 0;
        resp_or  = 1'b0;
        resp_and = 1'b1;
        while (cur_rdy(d3) == 1'b0 && lows < 20) begin
            resp_or  = resp_or | cur_resp(d3);
            resp_and = resp_and & cur_resp(d3);
            lows++;
            @(posedge HCLK); #1;
        end
        resp_or  = resp_or | cur_resp(d3);
        resp_and = resp_and & cur_resp(d3);
        rdata    = cur_rdata(d3);
        @(posedge HCLK); #1;
    endtask

    // Pipelined write immediately followed by a read on dut0.
    task automatic b2b(input string name, input logic [31:0] waddr, input logic [2:0] wsize,
                       input logic [31:0] wdata, input logic [31:0] raddr,
                       input logic [31:0] exp);
        hsel0  = 1'b1;
        htrans = 2'd2;
        haddr  = waddr;
        hwrite = 1'b1;
        hsize  = wsize;
        @(posedge HCLK); #1;
        check({name, "_rdy_wr"}, {31'b0, rdy0}, 32'd1);
        hwdata = wdata;
        haddr  = raddr;
        hwrite = 1'b0;
        hsize  = 3'd2;
        exp_q.push_back(exp);
        @(posedge HCLK); #1;
        hsel0  = 1'b0;
        htrans = 2'd0;
        check({name, "_rdy_rd"}, {31'b0, rdy0}, 32'd1);
        check({name, "_rdata"}, rdata0, exp_q.pop_front());
        @(posedge HCLK); #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          d3;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic        exp_resp;
        int          exp_lows;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit d3, input bit wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata, input bit chk_rd,
                       input logic [31:0] exp_rd, input logic exp_resp, input int exp_lows);
        vec_t v;
        v.d3 = d3; v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_resp = exp_resp; v.exp_lows = exp_lows;
        vecs.push_back(v);
    endtask

    // ---------------- main test ----------------
    initial begin
        logic [31:0] rd;
        logic        ro, ra;
        int          lows;

        HRESETn = 1'b0;
        hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'd0; haddr = '0; hwrite = 1'b0;
        hsize = 3'd2; hwdata = '0; mon_addr0 = '0; mon_addr3 = '0;

        //      d3 wr addr           size  wdata          chk rd            resp lows
        add(0, 1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 1, 32'h0000_0000, 0, 0);
        add(0, 0, 32'h0000_0010, 3'd2, 32'h0,         1, 32'hDEAD_BEEF, 0, 0);
        add(0, 1, 32'h0000_0020, 3'd2, 32'h1122_3344, 1, 32'hDEAD_BEEF, 0, 0);
        add(0, 1, 32'h0000_0022, 3'd0, 32'hFFAA_FFFF, 1, 32'hDEAD_BEEF, 0, 0);
        add(0, 1, 32'h0000_0020, 3'd1, 32'h1234_BEEF, 0, 32'h0,         0, 0);
        add(0, 0, 32'h0000_0020, 3'd2, 32'h0,         1, 32'h11AA_BEEF, 0, 0);
        add(0, 0, 32'h0000_0023, 3'd0, 32'h0,         1, 32'h11AA_BEEF, 0, 0);
        add(0, 1, 32'h0000_0022, 3'd1, 32'h5566_0000, 0, 32'h0,         0, 0);
        add(0, 0, 32'h0000_0020, 3'd1, 32'h0,         1, 32'h5566_BEEF, 0, 0);
        add(0, 1, 32'h0000_0400, 3'd2, 32'h0,         1, 32'h5566_BEEF, 1, 1);
        add(0, 0, 32'h0000_0041, 3'd2, 32'h0,         1, 32'h5566_BEEF, 1, 1);
        add(0, 1, 32'h0000_0010, 3'd3, 32'h0,         1, 32'h5566_BEEF, 1, 1);
        add(0, 0, 32'h0000_0011, 3'd1, 32'h0,         1, 32'h5566_BEEF, 1, 1);
        add(0, 0, 32'h0000_0010, 3'd2, 32'h0,         1, 32'hDEAD_BEEF, 0, 0);
        add(0, 1, 32'h0000_03FC, 3'd2, 32'h0F0F_0F0F, 0, 32'h0,         0, 0);
        add(0, 0, 32'h0000_03FC, 3'd2, 32'h0,         1, 32'h0F0F_0F0F, 0, 0);
        add(0, 0, 32'hFFFF_FFFC, 3'd2, 32'h0,         1, 32'h0F0F_0F0F, 1, 1);
        add(1, 1, 32'h0000_0040, 3'd2, 32'h0BAD_CAFE, 1, 32'h0000_0000, 0, 3);
        add(1, 0, 32'h0000_0040, 3'd2, 32'h0,         1, 32'h0BAD_CAFE, 0, 3);
        add(1, 1, 32'h0000_03FC, 3'd2, 32'hA5A5_5A5A, 0, 32'h0,         0, 3);
        add(1, 0, 32'h0000_03FC, 3'd2, 32'h0,         1, 32'hA5A5_5A5A, 0, 3);
        add(1, 0, 32'h0000_0400, 3'd2, 32'h0,         1, 32'hA5A5_5A5A, 1, 1);
        add(1, 1, 32'h0000_0042, 3'd1, 32'h7777_0000, 0, 32'h0,         0, 3);
        add(1, 0, 32'h0000_0040, 3'd2, 32'h0,         1, 32'h7777_CAFE, 0, 3);

        // Reset values
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_rdy0",   {31'b0, rdy0},  32'd1);
        check("rst_resp0",  {31'b0, resp0}, 32'd0);
        check("rst_rdata0", rdata0,         32'h0);
        check("rst_rdy3",   {31'b0, rdy3},  32'd1);
        check("rst_rdata3", rdata3,         32'h0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // Table-driven transfers
        foreach (vecs[i]) begin
            xfer(vecs[i].d3, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                 rd, ro, ra, lows);
            check($sformatf("v%0d_resp", i), {30'b0, ro, ra}, vecs[i].exp_resp ? 32'd3 : 32'd0);
            check($sformatf("v%0d_lows", i), 32'(lows), 32'(vecs[i].exp_lows));
            if (vecs[i].chk_rd) begin
                check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            end
        end

        // Backdoor view after the table
        mon_addr0 = 8'd4;  #1; check("mon0_w4",  mon0, 32'hDEAD_BEEF);
        mon_addr0 = 8'd8;  #1; check("mon0_w8",  mon0, 32'h5566_BEEF);
        mon_addr3 = 8'd16; #1; check("mon3_w16", mon3, 32'h7777_CAFE);
        @(posedge HCLK); #1;

        // Write then read of the same word on consecutive beats
        b2b("fwd_word", 32'h30, 3'd2, 32'hCAFE_F00D, 32'h30, 32'hCAFE_F00D);
        b2b("fwd_byte", 32'h31, 3'd0, 32'h0000_7700, 32'h30, 32'hCAFE_770D);
        b2b("no_fwd",   32'h34, 3'd2, 32'h1234_5678, 32'h30, 32'hCAFE_770D);
        mon_addr0 = 8'd13; #1; check("mon0_w13", mon0, 32'h1234_5678);
        mon_addr0 = 8'd12; #1; check("mon0_w12", mon0, 32'hCAFE_770D);

        // IDLE/BUSY beats and an unselected NONSEQ on the wait-state instance
        hsel3 = 1'b1; htrans = 2'd1; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
        @(posedge HCLK); #1;
        check("busy_rdy",  {31'b0, rdy3},  32'd1);
        check("busy_resp", {31'b0, resp3}, 32'd0);
        htrans = 2'd0;
        @(posedge HCLK); #1;
        check("idle_rdy",  {31'b0, rdy3},  32'd1);
        check("idle_resp", {31'b0, resp3}, 32'd0);
        hsel3 = 1'b0; htrans = 2'd2;
        @(posedge HCLK); #1;
        check("unsel_rdy", {31'b0, rdy3}, 32'd1);
        check("unsel_st",  {30'b0, st3},  32'd0);
        htrans = 2'd0;
        @(posedge HCLK); #1;

        // Reset in the middle of a waited write
        hsel3 = 1'b1; htrans = 2'd2; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
        @(posedge HCLK); #1;
        hsel3 = 1'b0; htrans = 2'd0; hwdata = 32'hFFFF_FFFF;
        check("wait_rdy", {31'b0, rdy3}, 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b0;
        #1;
        check("arst_rdy",   {31'b0, rdy3},  32'd1);
        check("arst_resp",  {31'b0, resp3}, 32'd0);
        check("arst_rdata", rdata3,         32'h0);
        check("arst_mon",   mon3,           32'h7777_CAFE);
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        repeat (5) @(posedge HCLK);
        #1;
        check("post_rst_mon3", mon3, 32'h7777_CAFE);
        mon_addr0 = 8'd4; #1;
        check("post_rst_mon0",   mon0,   32'hDEAD_BEEF);
        check("post_rst_rdata0", rdata0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
